// File: rtl/stage_ctrl_pkg.sv
// Shared stage codes, FSM state encoding and small helpers for the stage controller.
package stage_ctrl_pkg;

  // Stage codes shared with the kill counter and the display logic.
  localparam logic [3:0] ST_INIT  = 4'h0;
  localparam logic [3:0] ST_FIRST = 4'h1;
  localparam logic [3:0] ST_WIN   = 4'hE;
  localparam logic [3:0] ST_OVER  = 4'hF;

  // Game-flow states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CLEAR = 3'd2,
    S_WIN   = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // Intermission timer width: enough bits to hold CLEAR_CYCLES-1, never zero.
  function automatic int timer_width(input int cycles);
    int w;
    w = (cycles > 1) ? $clog2(cycles) : 1;
    return w;
  endfunction

  // Kills scored since the stage began; the 4-bit subtraction absorbs the 15->0 wrap.
  function automatic logic [3:0] kill_delta(input logic [3:0] kills, input logic [3:0] base);
    logic [3:0] d;
    d = kills - base;
    return d;
  endfunction

endpackage

// File: rtl/stage_ctrl_onepulse.sv
// Rising-edge detector for the start button. The armed flag stays low until the
// input has been seen low once after reset, so a button held through reset
// release does not count as a press.
module stage_ctrl_onepulse (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic pulse
);

  logic prev_q;
  logic prev_d;
  logic armed_q;
  logic armed_d;

  // Next history/armed values and the single-cycle pulse.
  always_comb begin
    prev_d  = sig_in;
    armed_d = armed_q | ~sig_in;
    pulse   = sig_in & ~prev_q & armed_q;
  end

  // History registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/stage_ctrl.sv
// Stage controller: sequences IDLE -> PLAY -> CLEAR -> PLAY ... -> WIN, with
// OVER on player death. Tracks the kill total at stage entry (base) so the
// per-stage kill count is a wrap-safe 4-bit difference.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int KILLS_PER_STAGE = 4,
  parameter int LAST_STAGE      = 3,
  parameter int CLEAR_CYCLES    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] kills,
  input  logic       player_dead,
  output logic [3:0] stage,
  output logic       in_play,
  output logic       clear_active,
  output logic [3:0] stage_kills
);

  localparam int             TW         = timer_width(CLEAR_CYCLES);
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
  localparam logic [3:0]     KILL_GOAL  = 4'(KILLS_PER_STAGE);
  localparam logic [3:0]     STAGE_MAX  = 4'(LAST_STAGE);

  state_e        state_q;
  state_e        state_d;
  logic [3:0]    stage_q;
  logic [3:0]    stage_d;
  logic [3:0]    base_q;
  logic [3:0]    base_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          in_play_q;
  logic          in_play_d;
  logic          clear_active_q;
  logic          clear_active_d;

  logic          start_op_s;
  logic [3:0]    delta_s;
  logic          goal_s;

  stage_ctrl_onepulse u_start_pulse (
    .clk    (clk),
    .rst    (rst),
    .sig_in (start),
    .pulse  (start_op_s)
  );

  // Per-stage kill count and goal detection from the live kill total.
  always_comb begin
    delta_s = kill_delta(kills, base_q);
    goal_s  = (delta_s >= KILL_GOAL);
    if (state_q == S_PLAY) begin
      stage_kills = delta_s;
    end else begin
      stage_kills = 4'h0;
    end
  end

  // Next-state logic for the game flow; player death outranks every other exit.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    base_d  = base_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start_op_s) begin
          state_d = S_PLAY;
          stage_d = ST_FIRST;
          base_d  = kills;
        end else begin
          stage_d = ST_INIT;
        end
      end
      S_PLAY: begin
        if (player_dead) begin
          state_d = S_OVER;
          stage_d = ST_OVER;
        end else if (goal_s && (stage_q == STAGE_MAX)) begin
          state_d = S_WIN;
          stage_d = ST_WIN;
        end else if (goal_s) begin
          state_d = S_CLEAR;
          timer_d = TIMER_LOAD;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_CLEAR: begin
        if (player_dead) begin
          state_d = S_OVER;
          stage_d = ST_OVER;
        end else if (timer_q == TIMER_ZERO) begin
          // Rebase on the kills seen now so intermission kills never count.
          state_d = S_PLAY;
          stage_d = stage_q + 4'h1;
          base_d  = kills;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      S_WIN, S_OVER: begin
        // Always pass through stage 0 so the kill counter gets cleared.
        if (start_op_s) begin
          state_d = S_IDLE;
          stage_d = ST_INIT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = ST_INIT;
        base_d  = 4'h0;
        timer_d = TIMER_ZERO;
      end
    endcase
  end

  // Moore status flags decoded from the next state so they register in step with it.
  always_comb begin
    in_play_d      = (state_d == S_PLAY);
    clear_active_d = (state_d == S_CLEAR);
  end

  // State and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      stage_q        <= ST_INIT;
      base_q         <= 4'h0;
      timer_q        <= TIMER_ZERO;
      in_play_q      <= 1'b0;
      clear_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      base_q         <= base_d;
      timer_q        <= timer_d;
      in_play_q      <= in_play_d;
      clear_active_q <= clear_active_d;
    end
  end

  assign stage        = stage_q;
  assign in_play      = in_play_q;
  assign clear_active = clear_active_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// Scoreboard bench for stage_ctrl with KILLS_PER_STAGE=4, LAST_STAGE=2, CLEAR_CYCLES=3.
// Inputs are driven on the falling edge; outputs are compared on the next falling edge.
module tb_stage_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] kills;
  logic       player_dead;
  logic [3:0] stage;
  logic       in_play;
  logic       clear_active;
  logic [3:0] stage_kills;

  int total;
  int bad;
  logic [9:0] exp_q[$];

  stage_ctrl #(
    .KILLS_PER_STAGE (4),
    .LAST_STAGE      (2),
    .CLEAR_CYCLES    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .kills        (kills),
    .player_dead  (player_dead),
    .stage        (stage),
    .in_play      (in_play),
    .clear_active (clear_active),
    .stage_kills  (stage_kills)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row = {start, kills, dead, stage, in_play, clear_active, stage_kills}.
  function automatic logic [15:0] pk(input int s, input int k, input int d,
                                     input int stg, input int ip, input int ca, input int sk);
    logic [31:0] sv, kv, dv, gv, iv, cv, xv;
    sv = s; kv = k; dv = d; gv = stg; iv = ip; cv = ca; xv = sk;
    return {sv[0], kv[3:0], dv[0], gv[3:0], iv[0], cv[0], xv[3:0]};
  endfunction

  function automatic logic [9:0] obs();
    return {stage, in_play, clear_active, stage_kills};
  endfunction

  task automatic drive_row(input logic [15:0] r);
    start       = r[15];
    kills       = r[14:11];
    player_dead = r[10];
    exp_q.push_back(r[9:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] e;
    logic [9:0] got;
    rst = 1'b1; start = 1'b0; kills = 4'h0; player_dead = 1'b0;
    #3;
    rst = 1'b0;
    exp_q.push_back(10'h000);
    #1;
    e = exp_q.pop_front(); got = obs(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_async got=%h exp=%h", got, e); end
    exp_q.push_back(10'h000);
    tick(); tick();
    e = exp_q.pop_front(); got = obs(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_held got=%h exp=%h", got, e); end
    rst = 1'b1;
  endtask

  task automatic test_start();
    logic [15:0] rows[$];
    logic [9:0] e;
    logic [9:0] got;
    rows.push_back(pk(0, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  1, 1, 0, 0));
    rows.push_back(pk(0, 0, 0,  1, 1, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL start[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_clear();
    logic [15:0] rows[$];
    logic [9:0] e;
    logic [9:0] got;
    rows.push_back(pk(0, 1, 0,  1, 1, 0, 1));
    rows.push_back(pk(0, 3, 0,  1, 1, 0, 3));
    rows.push_back(pk(0, 4, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 5, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 6, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 6, 0,  2, 1, 0, 0));
    rows.push_back(pk(1, 7, 0,  2, 1, 0, 1));
    rows.push_back(pk(0, 7, 0,  2, 1, 0, 1));
    foreach (rows[i]) begin
      drive_row(rows[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL clear[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_over_restart();
    logic [15:0] rows[$];
    logic [9:0] e;
    logic [9:0] got;
    rows.push_back(pk(0, 7, 1, 15, 0, 0, 0));
    rows.push_back(pk(0, 0, 0, 15, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(0, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  1, 1, 0, 0));
    rows.push_back(pk(0, 0, 0,  1, 1, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL over_restart[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_dead_priority();
    logic [15:0] rows[$];
    logic [9:0] e;
    logic [9:0] got;
    rows.push_back(pk(0, 2, 0,  1, 1, 0, 2));
    rows.push_back(pk(0, 4, 1, 15, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(0, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  1, 1, 0, 0));
    rows.push_back(pk(0, 4, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 5, 1, 15, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(0, 0, 0,  0, 0, 0, 0));
    rows.push_back(pk(1, 0, 0,  1, 1, 0, 0));
    rows.push_back(pk(0, 0, 0,  1, 1, 0, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL dead_priority[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] rows[$];
    logic [15:0] tail[$];
    logic [9:0] e;
    logic [9:0] got;
    rows.push_back(pk(0,  4, 0,  1, 0, 1, 0));
    rows.push_back(pk(0,  8, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 12, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 14, 0,  2, 1, 0, 0));
    rows.push_back(pk(0, 15, 0,  2, 1, 0, 1));
    foreach (rows[i]) begin
      drive_row(rows[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL wrap[%0d] got=%h exp=%h", i, got, e); end
    end
    // kills 15 -> 2 across the wrap: count reads 4 before the edge, win after it.
    drive_row(pk(0, 2, 0, 2, 1, 0, 4));
    #1;
    e = exp_q.pop_front(); got = obs(); total++;
    if (got !== e) begin bad++; $display("FAIL wrap_count got=%h exp=%h", got, e); end
    tail.push_back(pk(0, 2, 0, 14, 0, 0, 0));
    tail.push_back(pk(0, 0, 0, 14, 0, 0, 0));
    tail.push_back(pk(1, 0, 0,  0, 0, 0, 0));
    tail.push_back(pk(0, 0, 0,  0, 0, 0, 0));
    foreach (tail[i]) begin
      drive_row(tail[i]);
      if (i == 0) @(posedge clk); else tick();
      if (i == 0) @(negedge clk);
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL win[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] rows[$];
    logic [15:0] post[$];
    logic [9:0] e;
    logic [9:0] got;
    rows.push_back(pk(1, 0, 0,  1, 1, 0, 0));
    rows.push_back(pk(0, 0, 0,  1, 1, 0, 0));
    rows.push_back(pk(0, 4, 0,  1, 0, 1, 0));
    rows.push_back(pk(0, 4, 0,  1, 0, 1, 0));
    foreach (rows[i]) begin
      drive_row(rows[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL pre_reset[%0d] got=%h exp=%h", i, got, e); end
    end
    // Timer is at 1 here; drop reset between clock edges with start held high.
    start = 1'b1;
    kills = 4'h0;
    rst   = 1'b0;
    exp_q.push_back(10'h000);
    #1;
    e = exp_q.pop_front(); got = obs(); total++;
    if (got !== e) begin bad++; $display("FAIL mid_clear_reset got=%h exp=%h", got, e); end
    tick();
    rst = 1'b1;
    post.push_back(pk(1, 0, 0,  0, 0, 0, 0));
    post.push_back(pk(1, 0, 0,  0, 0, 0, 0));
    post.push_back(pk(0, 0, 0,  0, 0, 0, 0));
    post.push_back(pk(1, 0, 0,  1, 1, 0, 0));
    foreach (post[i]) begin
      drive_row(post[i]); tick();
      e = exp_q.pop_front(); got = obs(); total++;
      if (got !== e) begin bad++; $display("FAIL held_start[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_start();
    test_clear();
    test_over_restart();
    test_dead_priority();
    test_wrap();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d need=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
